// File: rtl/return_stack_if.sv
// Call/return port bundle between the control unit (master) and the return-address stack (slave).
interface return_stack_if #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
);
   logic                     push;
   logic                     pop;
   logic [WIDTH-1:0]         pc_in;
   logic [WIDTH-1:0]         top_out;
   logic                     empty;
   logic                     full;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     underflow;

   modport master (
      output push, pop, pc_in,
      input  top_out, empty, full, count, overflow, underflow
   );

   modport slave (
      input  push, pop, pc_in,
      output top_out, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/return_stack.sv
// Circular LIFO of return addresses with occupancy count and sticky overflow/underflow flags.
module return_stack #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input logic           clk,
   input logic           reset,
   return_stack_if.slave rs
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    wp_nxt;
   logic [PW-1:0]    top_idx;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             overflow;
   logic             underflow;
   logic             empty;
   logic             full;
   logic             wr_en;
   logic [PW-1:0]    wr_addr;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign top_idx = wp - PW'(1);

   // push+pop on a non-empty stack replaces the top in place; otherwise writes go to the next free slot
   always_comb begin
      wr_en     = rs.push;
      wr_addr   = (rs.pop && !empty) ? top_idx : wp;
      wp_nxt    = wp;
      count_nxt = count;
      unique case ({rs.push, rs.pop})
         2'b10: begin
            wp_nxt = wp + PW'(1);
            if (!full)
               count_nxt = count + CW'(1);
         end
         2'b01: begin
            if (!empty) begin
               wp_nxt    = top_idx;
               count_nxt = count - CW'(1);
            end
         end
         2'b11: begin
            if (empty) begin
               wp_nxt    = wp + PW'(1);
               count_nxt = CW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp        <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wp    <= wp_nxt;
         count <= count_nxt;
         if (rs.push && !rs.pop && full)
            overflow <= 1'b1;
         if (rs.pop && empty)
            underflow <= 1'b1;
      end
   end

   // storage is deliberately not reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= rs.pc_in;
   end

   assign rs.top_out   = empty ? '0 : mem[top_idx];
   assign rs.empty     = empty;
   assign rs.full      = full;
   assign rs.count     = count;
   assign rs.overflow  = overflow;
   assign rs.underflow = underflow;
endmodule

// File: tb/tb_return_stack.sv
// Directed table-driven bench for return_stack plus hand sequences for overflow, pop-cycle visibility and async reset.
module tb_return_stack;
   localparam int WIDTH = 10;
   localparam int DEPTH = 8;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   return_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rs ();

   return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .rs    (rs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        push;
      logic        pop;
      logic [9:0]  pc;
      logic [9:0]  top;
      logic [3:0]  cnt;
      logic        e;
      logic        f;
      logic        o;
      logic        u;
   } vec_t;

   vec_t tv [$];

   function automatic vec_t mk(logic pu, logic po, logic [9:0] pc, logic [9:0] top,
                               logic [3:0] cnt, logic e, logic f, logic o, logic u);
      vec_t v;
      v.push = pu; v.pop = po; v.pc = pc; v.top = top; v.cnt = cnt;
      v.e = e; v.f = f; v.o = o; v.u = u;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_state(string tag, logic [9:0] top, logic [3:0] cnt,
                            logic e, logic f, logic o, logic u);
      chk({tag, ".top"},   32'(rs.top_out),   32'(top));
      chk({tag, ".count"}, 32'(rs.count),     32'(cnt));
      chk({tag, ".empty"}, 32'(rs.empty),     32'(e));
      chk({tag, ".full"},  32'(rs.full),      32'(f));
      chk({tag, ".ovf"},   32'(rs.overflow),  32'(o));
      chk({tag, ".unf"},   32'(rs.underflow), 32'(u));
   endtask

   // inputs change 1 time unit after a rising edge; the edge then applies them
   task automatic step(logic pu, logic po, logic [9:0] pc);
      rs.push  = pu;
      rs.pop   = po;
      rs.pc_in = pc;
      @(posedge clk);
      #1;
      rs.push = 1'b0;
      rs.pop  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      rs.push  = 1'b0;
      rs.pop   = 1'b0;
      rs.pc_in = '0;
      do_reset();
      repeat (3) step(1'b0, 1'b0, 10'h000);
      chk_state("reset_idle", 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      //          push  pop   pc_in    top      cnt   e     f     o     u
      tv.push_back(mk(1'b1, 1'b0, 10'h011, 10'h011, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 1'b0, 10'h022, 10'h022, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 1'b0, 10'h033, 10'h033, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 1'b1, 10'h000, 10'h022, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 1'b1, 10'h000, 10'h011, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 1'b1, 10'h000, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 1'b1, 10'h000, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));
      tv.push_back(mk(1'b1, 1'b0, 10'h044, 10'h044, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
      tv.push_back(mk(1'b1, 1'b0, 10'h055, 10'h055, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1));
      tv.push_back(mk(1'b1, 1'b1, 10'h0AA, 10'h0AA, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1));
      tv.push_back(mk(1'b0, 1'b1, 10'h000, 10'h044, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
      tv.push_back(mk(1'b0, 1'b1, 10'h000, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));
      tv.push_back(mk(1'b0, 1'b0, 10'h3FF, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));
      tv.push_back(mk(1'b1, 1'b1, 10'h0AA, 10'h0AA, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
      tv.push_back(mk(1'b0, 1'b1, 10'h000, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));

      foreach (tv[i]) begin
         step(tv[i].push, tv[i].pop, tv[i].pc);
         chk_state($sformatf("vec%0d", i), tv[i].top, tv[i].cnt,
                   tv[i].e, tv[i].f, tv[i].o, tv[i].u);
      end

      // pop cycle shows the entry being returned to before the edge
      do_reset();
      step(1'b1, 1'b0, 10'h011);
      step(1'b1, 1'b0, 10'h022);
      step(1'b1, 1'b0, 10'h033);
      for (int i = 0; i < 3; i++) begin
         rs.pop = 1'b1;
         #1;
         chk($sformatf("popcycle%0d.top", i), 32'(rs.top_out), 32'(10'h033 - 10'(i * 'h11)));
         @(posedge clk);
         #1 rs.pop = 1'b0;
      end
      chk_state("popcycle_end", 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // overflow: nine pushes into eight slots lose the oldest entry
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b0, 10'(10'h100 + i));
         if (i == 7)
            chk_state("ovf_at_full", 10'h107, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk_state("ovf_after9", 10'h108, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         rs.pop = 1'b1;
         #1;
         chk($sformatf("ovf_pop%0d.top", i), 32'(rs.top_out), 32'(10'h108 - 10'(i)));
         @(posedge clk);
         #1 rs.pop = 1'b0;
      end
      chk_state("ovf_drained", 10'h000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 10'h000);
      chk_state("ovf_then_unf", 10'h000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      // asynchronous reset between edges
      do_reset();
      step(1'b1, 1'b0, 10'h3FF);
      step(1'b1, 1'b0, 10'h3FF);
      chk_state("pre_async", 10'h3FF, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk_state("async_rst", 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b1, 1'b0, 10'h001);
      chk_state("post_rst_push", 10'h001, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 10'h000);
      chk_state("post_rst_pop", 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack for the processor's subroutine call and return instructions. It sits in the PC path directly downstream of the control unit: `push` is driven by the unit's `enablebackup` (call), and `pop` by its `s_ret` (return). It saves the incremented PC on a call and presents the saved return address to the PC mux during a return. It is a LIFO with a circular store, occupancy count and sticky overflow/underflow flags.

## Interface
- `WIDTH`, 10, PC / return-address width in bits
- `DEPTH`, 8, number of entries; must be a power of two, at least 2
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; low clears the stack immediately
- `push`  in  1  call: store `pc_in` as the new top (from `enablebackup`)
- `pop`  in  1  return: discard the top (from `s_ret`)
- `pc_in`  in  WIDTH  return address to save (PC+1 of the call instruction)
- `top_out`  out  WIDTH  current top entry, combinational; 0 when empty
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `count`  out  clog2(DEPTH)+1  number of valid entries
- `overflow`  out  1  sticky: a push happened while full
- `underflow`  out  1  sticky: a pop happened while empty

## Operation
- Internal state:
  - `wp`, clog2(DEPTH) bits: next write slot.
  - `count`.
  - Storage array `mem[DEPTH]`.
  - Top index is `wp-1` modulo DEPTH; all pointer arithmetic wraps naturally at DEPTH.
- Reset (`reset` low, asynchronous): `wp`=0, `count`=0, `overflow`=0, `underflow`=0.
  - `mem` is not cleared.
  - Resulting outputs: `top_out`=0, `empty`=1, `full`=0.
  - Reset mid-operation discards all entries; the first push after release goes to slot 0.
- Per-edge actions, decided on {push, pop}:
  - 00: hold.
  - 10, not full: `mem[wp]`<=`pc_in`; `wp`+1; `count`+1.
  - 10, full: `mem[wp]`<=`pc_in` (overwrites the oldest entry); `wp`+1; `count` stays DEPTH; `overflow`<=1.
  - 01, not empty: `wp`-1; `count`-1.
  - 01, empty: no pointer or count change; `underflow`<=1.
  - 11, not empty: `mem[wp-1]`<=`pc_in` (top replaced); `wp` and `count` unchanged.
  - 11, empty: `underflow`<=1, then a plain push (`mem[wp]`<=`pc_in`, `wp`+1, `count`=1).
- `top_out` = `mem[wp-1]` when `count`>0, else 0.
  - Purely combinational from the registered state and array.
  - During a return, the PC mux uses the value present in the same cycle `pop` is high.
- `overflow` and `underflow` clear only on reset.
- Push data is never lost silently: an overwrite always sets `overflow`.

## Timing
- Push latency: the new value appears on `top_out` in the cycle after the push edge.
- Pop: `top_out` shows the entry being returned to during the pop cycle. The next entry down (or 0) appears after the edge.
- `count`, `empty`, `full` and the flags are registered or decoded from registered state, and update one edge after the triggering cycle.
- Back-to-back call/return in consecutive cycles is supported at full rate; no stall or handshake.
- Reset assertion affects outputs without waiting for `clk`. Deassertion is assumed synchronous to `clk` upstream.

## Test plan
- Reset, then idle 3 cycles -> `empty`=1, `count`=0, `top_out`=0, both flags 0.
- Push 0x011, 0x022, 0x033 on consecutive cycles -> `top_out` 0x033, `count`=3. Then pop 3 times -> `top_out` is 0x033, 0x022, 0x011 during the successive pop cycles, then 0, with `empty`=1.
- DEPTH=8: push 0x100..0x108 (9 values) -> `full`=1, `overflow`=1, `count`=8. Then 8 pops return 0x108 down to 0x101; 0x100 is lost.
- Pop when empty -> `underflow`=1, `count` stays 0, `top_out`=0. Flag persists through later pushes until reset.
- With `count`=2, top 0x055: assert push=pop=1 with `pc_in`=0x0AA -> `count`=2, `top_out`=0x0AA, next pop exposes the original lower entry. With empty stack, push=pop with 0x0AA -> `underflow`=1, `count`=1, `top_out`=0x0AA.
- Push 0x3FF twice, pull `reset` low mid-cycle between edges -> outputs go to reset values immediately. After release, push 0x001 -> `count`=1, `top_out`=0x001.
